// File: rtl/rr_mux_pkg.sv
// Shared definitions for the 4-to-1 round-robin valid/ready merge.
// Optional feature macro: RR_MUX_CNT_EN (per-channel transfer counters).

package rr_mux_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

`ifdef RR_MUX_CNT_EN
   localparam int CNT_W = 16;
`endif

   // Output buffer occupancy
   typedef enum logic [0:0] {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   // Encode a one-hot (or zero) channel vector into a channel index
   function automatic sel_t onehot_to_sel(input logic [NCH-1:0] oh);
      sel_t idx;
      idx = {SEL_W{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         idx = idx | (oh[k] ? sel_t'(k) : {SEL_W{1'b0}});
      end
      return idx;
   endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_mux_4x1_arb.sv
// Combinational 4-way round-robin arbiter. The search starts one past the
// last granted channel (ptr) and wraps, so ptr itself is checked last.

module rr_arb_4
   import rr_mux_pkg::*;
(
   input  logic [NCH-1:0] req,
   input  sel_t           ptr,
   output logic [NCH-1:0] gnt
);

   logic [NCH-1:0] gnt_s;

   // Grant the first requesting channel in the order ptr+1, ptr+2, ptr+3, ptr
   always_comb begin : p_arb
      logic found_s;
      sel_t cand_s;
      gnt_s   = {NCH{1'b0}};
      found_s = 1'b0;
      cand_s  = {SEL_W{1'b0}};
      for (int i = 1; i <= NCH; i++) begin
         cand_s = ptr + sel_t'(i);
         if (!found_s && req[cand_s]) begin
            gnt_s[cand_s] = 1'b1;
            found_s       = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign gnt = gnt_s;

endmodule : rr_arb_4

// File: rtl/rr_mux_4x1.sv
// Four valid/ready input streams merged into one registered output stream
// with round-robin fairness. The output register is a one-deep buffer that
// can be popped and refilled in the same cycle, giving full throughput.
// Optional feature macro: RR_MUX_CNT_EN adds xfer_cnt, one 16-bit transfer
// counter per input channel.

module rr_mux_4x1
   import rr_mux_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         in_valid,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic [NCH-1:0]         in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       out_sel
`ifdef RR_MUX_CNT_EN
   ,
   output logic [NCH*CNT_W-1:0]   xfer_cnt
`endif
);

   // Registered state
   buf_state_t       state_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   sel_t             out_sel_r;
   sel_t             ptr_r;

   // Combinational handshake signals
   logic [NCH-1:0]   grant_s;
   logic             load_s;
   logic [NCH-1:0]   in_ready_s;
   logic [NCH-1:0]   xfer_vec_s;
   logic             xfer_s;
   sel_t             xfer_sel_s;
   logic [WIDTH-1:0] xfer_data_s;

   rr_arb_4 u_arb (
      .req (in_valid),
      .ptr (ptr_r),
      .gnt (grant_s)
   );

   // The buffer can take a word when empty or when it is being drained
   assign load_s = ~out_valid_r | out_ready;

   // Offer ready only to the granted channel, and never while in reset
   always_comb begin
      if (rst) begin
         in_ready_s = {NCH{1'b0}};
      end else begin
         in_ready_s = grant_s & {NCH{load_s}};
      end
   end

   // Identify the accepted channel and its data word
   always_comb begin
      xfer_vec_s  = in_valid & in_ready_s;
      xfer_s      = |xfer_vec_s;
      xfer_sel_s  = onehot_to_sel(grant_s);
      xfer_data_s = in_data[int'(xfer_sel_s)*WIDTH +: WIDTH];
   end

   // Output buffer FSM: capture on push, clear on pop-without-push, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= BUF_EMPTY;
         out_valid_r <= 1'b0;
         out_data_r  <= {WIDTH{1'b0}};
         out_sel_r   <= {SEL_W{1'b0}};
         ptr_r       <= 2'd3;
      end else begin
         case (state_r)
            BUF_EMPTY: begin
               if (xfer_s) begin
                  state_r     <= BUF_FULL;
                  out_valid_r <= 1'b1;
                  out_data_r  <= xfer_data_s;
                  out_sel_r   <= xfer_sel_s;
                  ptr_r       <= xfer_sel_s;
               end else begin
                  state_r     <= BUF_EMPTY;
                  out_valid_r <= 1'b0;
               end
            end
            BUF_FULL: begin
               if (xfer_s) begin
                  state_r     <= BUF_FULL;
                  out_valid_r <= 1'b1;
                  out_data_r  <= xfer_data_s;
                  out_sel_r   <= xfer_sel_s;
                  ptr_r       <= xfer_sel_s;
               end else if (out_ready) begin
                  state_r     <= BUF_EMPTY;
                  out_valid_r <= 1'b0;
               end else begin
                  state_r     <= BUF_FULL;
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= BUF_EMPTY;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_sel   = out_sel_r;

`ifdef RR_MUX_CNT_EN
   logic [CNT_W-1:0]     cnt_r [NCH];
   logic [NCH*CNT_W-1:0] xfer_cnt_s;

   // Per-channel transfer counters, wrapping naturally at 16'hFFFF
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            cnt_r[k] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (xfer_vec_s[k]) begin
               cnt_r[k] <= cnt_r[k] + CNT_W'(1);
            end else begin
               cnt_r[k] <= cnt_r[k];
            end
         end
      end
   end

   // Pack the counters into the flat output port, channel k in slice k
   always_comb begin
      xfer_cnt_s = {(NCH*CNT_W){1'b0}};
      for (int k = 0; k < NCH; k++) begin
         xfer_cnt_s[k*CNT_W +: CNT_W] = cnt_r[k];
      end
   end

   assign xfer_cnt = xfer_cnt_s;
`endif

endmodule : rr_mux_4x1

// File: doc/rr_mux_4x1.md
RR_MUX_4X1 -- requirements
Module: rr_mux_4x1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the data width of every input and output channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 4 bits: per-channel valid, where bit k belongs to channel k.
REQ-005 SHALL have port in_data, input, 4 x WIDTH bits: per-channel data, where slice k belongs to channel k.
REQ-006 SHALL have port in_ready, output, 4 bits: per-channel ready, one-hot or zero.
REQ-007 SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the word.
REQ-009 SHALL have port out_data, output, WIDTH bits: the registered word.
REQ-010 SHALL have port out_sel, output, 2 bits: the index of the channel that supplied out_data.

Function
REQ-011 SHALL merge four valid/ready input streams into one output stream; it is the collecting counterpart of the 1x4 demux.
REQ-012 SHALL treat a transfer as occurring on a channel in any cycle where valid and ready are both 1 on that channel.
REQ-013 SHALL keep a 2-bit round-robin pointer ptr holding the last granted channel; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 SHALL form the combinational grant from in_valid and ptr: exactly one bit for the first valid channel in search order, or zero when no channel is valid.
REQ-015 SHALL define load = ~out_valid | out_ready, and drive in_ready = grant & {4{load}}.
REQ-016 SHALL, on an input transfer from channel k, set out_data <= in_data[k], out_sel <= k, out_valid <= 1 and ptr <= k.
REQ-017 SHALL, when out_valid & out_ready and no input transfer occurs, set out_valid <= 0.
REQ-018 SHALL treat the output buffer as a two-state machine: EMPTY (out_valid=0) goes to FULL on an input transfer; FULL stays FULL on a simultaneous pop and push, and goes to EMPTY on a pop with no push.
REQ-019 SHALL give a latency of 1 cycle from an input transfer to out_valid, and sustain one word per cycle while out_ready=1.
REQ-020 SHALL hold out_data, out_sel and out_valid stable while out_valid=1 and out_ready=0, with in_ready=0.
REQ-021 SHALL leave ptr unchanged in any cycle with no input transfer.
REQ-022 SHALL not require an input channel to keep valid asserted unless that channel is granted.
REQ-023 SHALL never drop, duplicate or reorder words within a single channel.

Reset
REQ-024 SHALL, while rst=1, immediately force out_valid=0, out_data=0, out_sel=0 and ptr=3, so that channel 0 has first priority after reset.
REQ-025 SHALL discard a word still held in the output register when rst asserts mid-operation.
REQ-026 SHALL hold in_ready at 0 while rst=1.

Configuration
REQ-027 SHALL use macro RR_MUX_CNT_EN; when it is defined, the block adds output port xfer_cnt, 4 x 16 bits, a per-channel count of input transfers.
REQ-028 SHALL make each xfer_cnt counter reset to 0, wrap from 16'hFFFF to 0, and increment in the cycle of its channel's transfer.
REQ-029 SHALL omit the xfer_cnt port and its counters when RR_MUX_CNT_EN is undefined, with all other behaviour identical.

Structure
REQ-030 SHALL put in shared package rr_mux_pkg: constant NCH=4, constant SEL_W=2, typedef sel_t (logic [SEL_W-1:0]) and, under RR_MUX_CNT_EN, constant CNT_W=16.
REQ-031 SHALL place the combinational round-robin arbiter in sub-module rr_arb_4, with inputs req[3:0] and ptr and output one-hot gnt[3:0]; the pointer and output register stay in rr_mux_4x1.

Verification
REQ-032 SHALL cover: reset, then in_valid=4'b0100 with in_data[2]=8'hA5 -> in_ready=4'b0100, and on the next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-033 SHALL cover: in_valid=4'b1111 held with out_ready=1 after reset -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 SHALL cover: out_valid=1 with out_ready=0 held for 3 cycles -> out_data and out_sel unchanged and in_ready=4'b0000 throughout.
REQ-035 SHALL cover: ptr=1 with in_valid=4'b0011 -> channel 0 granted first, then channel 1.
REQ-036 SHALL cover: rst asserted asynchronously while out_valid=1 -> out_valid=0 before the next clock edge, and ptr=3.
REQ-037 SHALL cover, with RR_MUX_CNT_EN defined: 5 transfers on channel 3 -> xfer_cnt[3]=5 and all other counters 0.
